// File: rtl/icache_dm.sv
// ---------------------------------------------------------------------------
// icache_dm : direct-mapped instruction cache, one 32-bit word per line.
//
// Sits between instruction fetch and the memory controller's instruction
// port. Hits return in one cycle. A miss issues a single word read and
// fills the line. A flush suppresses the pending response, but an
// in-flight memory read still completes and fills its line.
//
// Ports:
//   clk          system clock
//   rst          asynchronous reset, active low
//   rdy          global enable; when low every register holds
//   fetch_req    fetch request, taken only while fetch_ready=1
//   fetch_addr   instruction byte address (bits [1:0] ignored)
//   fetch_ready  cache idle and able to take a request
//   fetch_ok     one-cycle pulse, fetch_inst is valid
//   fetch_inst   returned instruction word
//   flush        drop the pending / in-flight response
//   mem_req      read request to the memory controller
//   mem_addr     word-aligned miss address
//   mem_done     one-cycle completion pulse from the memory controller
//   mem_data     fill word, valid while mem_done=1
// ---------------------------------------------------------------------------
module icache_dm #(
    parameter int IDX_W  = 8,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_ready,
    output logic              fetch_ok,
    output logic [31:0]       fetch_inst,
    input  logic              flush,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_done,
    input  logic [31:0]       mem_data
);

    localparam int LINES = 1 << IDX_W;
    localparam int TAG_W = ADDR_W - IDX_W - 2;

    typedef enum logic {
        IDLE = 1'b0,
        MISS = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic [LINES-1:0] valid_q;
    logic [TAG_W-1:0] tag_mem  [LINES];
    logic [31:0]      data_mem [LINES];

    logic             kill_q;
    logic [IDX_W-1:0] miss_idx_q;
    logic [TAG_W-1:0] miss_tag_q;

    logic [IDX_W-1:0] fetch_idx;
    logic [TAG_W-1:0] fetch_tag;
    logic             lookup_hit;
    logic             take_req;
    logic             fill;

    assign fetch_idx  = fetch_addr[IDX_W+1:2];
    assign fetch_tag  = fetch_addr[ADDR_W-1:IDX_W+2];
    assign lookup_hit = valid_q[fetch_idx] && (tag_mem[fetch_idx] == fetch_tag);

    // flush outranks fetch_req; nothing is taken while the block is stalled
    assign take_req = rdy && fetch_req && !flush && (state_q == IDLE);
    assign fill     = rdy && mem_done && (state_q == MISS);

    // ---- state register ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // mem_req must already be low in the completion cycle, otherwise the
    // controller would start a second read on that same edge.
    // While stalled (rdy=0) mem_done is disregarded so mem_req holds.
    always_comb begin
        state_d     = state_q;
        fetch_ready = 1'b0;
        mem_req     = 1'b0;
        case (state_q)
            IDLE: begin
                fetch_ready = 1'b1;
                if (take_req && !lookup_hit) begin
                    state_d = MISS;
                end
            end
            MISS: begin
                mem_req = !(rdy && mem_done);
                if (fill) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ---- response / control registers ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q    <= '0;
            kill_q     <= 1'b0;
            fetch_ok   <= 1'b0;
            fetch_inst <= '0;
            mem_addr   <= '0;
        end else if (rdy) begin
            fetch_ok <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (take_req) begin
                        if (lookup_hit) begin
                            fetch_ok   <= 1'b1;
                            fetch_inst <= data_mem[fetch_idx];
                        end else begin
                            mem_addr <= fetch_addr & ~ADDR_W'(3);
                            kill_q   <= 1'b0;
                        end
                    end
                end
                MISS: begin
                    if (flush) begin
                        kill_q <= 1'b1;
                    end
                    if (mem_done) begin
                        valid_q[miss_idx_q] <= 1'b1;
                        // a flush now or earlier in this miss swallows the reply
                        if (!kill_q && !flush) begin
                            fetch_ok   <= 1'b1;
                            fetch_inst <= mem_data;
                        end
                    end
                end
                default: begin
                    kill_q <= 1'b0;
                end
            endcase
        end
    end

    // ---- line storage and miss bookkeeping (not reset) ----
    always_ff @(posedge clk) begin
        if (take_req && !lookup_hit) begin
            miss_idx_q <= fetch_idx;
            miss_tag_q <= fetch_tag;
        end
        if (fill) begin
            data_mem[miss_idx_q] <= mem_data;
            tag_mem[miss_idx_q]  <= miss_tag_q;
        end
    end

endmodule

// File: tb/tb_icache_dm.sv
// ---------------------------------------------------------------------------
// tb_icache_dm : self-checking bench for icache_dm.
//
// The reference keeps a backing memory image (words created on first use)
// and, per line, the word address the cache should currently hold. A fetch
// is a hit exactly when its line holds its word address; the returned data
// is always the memory image word. The bench plays the memory controller.
// ---------------------------------------------------------------------------
module tb_icache_dm;

    localparam int IDX_W  = 8;
    localparam int ADDR_W = 32;
    localparam int LINES  = 1 << IDX_W;

    logic        clk;
    logic        rst;
    logic        rdy;
    logic        fetch_req;
    logic [31:0] fetch_addr;
    logic        fetch_ready;
    logic        fetch_ok;
    logic [31:0] fetch_inst;
    logic        flush;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_done;
    logic [31:0] mem_data;

    int checks;
    int errors;

    logic [31:0] mem_img   [int unsigned];
    logic [31:0] line_word [int unsigned];

    icache_dm #(
        .IDX_W (IDX_W),
        .ADDR_W(ADDR_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rdy        (rdy),
        .fetch_req  (fetch_req),
        .fetch_addr (fetch_addr),
        .fetch_ready(fetch_ready),
        .fetch_ok   (fetch_ok),
        .fetch_inst (fetch_inst),
        .flush      (flush),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_done   (mem_done),
        .mem_data   (mem_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic void check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        int unsigned w;
        w = addr >> 2;
        if (!mem_img.exists(w)) begin
            mem_img[w] = (w == 32'h400) ? 32'h0050_0093 : $urandom;
        end
        return mem_img[w];
    endfunction

    function automatic bit model_hit(input logic [31:0] addr);
        int unsigned w;
        w = addr >> 2;
        return line_word.exists(w % LINES) && (line_word[w % LINES] == w);
    endfunction

    // One fetch from IDLE. d = cycles from miss entry to mem_done (>=1).
    // fmode: 0 no flush, 1 flush one cycle into the miss, 2 flush with mem_done.
    // freeze: drop rdy for 3 cycles inside the miss.
    task automatic do_fetch(input logic [31:0] addr, input int d, input int fmode, input bit freeze);
        logic [31:0] exp_data;
        logic [31:0] exp_maddr;
        bit          hit;
        int          dd;
        int          fm;
        dd        = d;
        fm        = fmode;
        hit       = model_hit(addr);
        exp_data  = mem_word(addr);
        exp_maddr = addr & 32'hFFFF_FFFC;
        if ((fm == 1 || freeze) && dd < 2) dd = 2;
        check("ready_before", {31'd0, fetch_ready}, 32'd1);
        fetch_req  = 1'b1;
        fetch_addr = addr;
        @(posedge clk); #1;
        fetch_req  = 1'b0;
        fetch_addr = $urandom;
        if (hit) begin
            check("hit_ok", {31'd0, fetch_ok}, 32'd1);
            check("hit_inst", fetch_inst, exp_data);
            check("hit_no_mreq", {31'd0, mem_req}, 32'd0);
        end else begin
            check("miss_no_ok", {31'd0, fetch_ok}, 32'd0);
            check("miss_mreq", {31'd0, mem_req}, 32'd1);
            check("miss_maddr", mem_addr, exp_maddr);
            check("miss_busy", {31'd0, fetch_ready}, 32'd0);
            for (int i = 1; i < dd; i++) begin
                if (freeze && i == 1) begin
                    rdy = 1'b0;
                    repeat (3) begin
                        @(posedge clk); #1;
                        check("frz_mreq", {31'd0, mem_req}, 32'd1);
                        check("frz_maddr", mem_addr, exp_maddr);
                        check("frz_busy", {31'd0, fetch_ready}, 32'd0);
                        check("frz_no_ok", {31'd0, fetch_ok}, 32'd0);
                    end
                    rdy = 1'b1;
                end
                flush = (fm == 1 && i == 1);
                @(posedge clk); #1;
                flush = 1'b0;
                check("wait_mreq", {31'd0, mem_req}, 32'd1);
                check("wait_maddr", mem_addr, exp_maddr);
                check("wait_no_ok", {31'd0, fetch_ok}, 32'd0);
            end
            mem_done = 1'b1;
            mem_data = exp_data;
            flush    = (fm == 2);
            #1;
            check("mreq_low_on_done", {31'd0, mem_req}, 32'd0);
            @(posedge clk); #1;
            mem_done = 1'b0;
            flush    = 1'b0;
            mem_data = $urandom;
            check("fill_ok", {31'd0, fetch_ok}, (fm == 0) ? 32'd1 : 32'd0);
            if (fm == 0) check("fill_inst", fetch_inst, exp_data);
            check("after_no_mreq", {31'd0, mem_req}, 32'd0);
            check("after_ready", {31'd0, fetch_ready}, 32'd1);
            line_word[(addr >> 2) % LINES] = addr >> 2;
        end
    endtask

    initial begin
        logic [31:0] a3 [3];
        logic [31:0] ra;
        logic [31:0] exp_data;
        int          fm;

        checks     = 0;
        errors     = 0;
        rst        = 1'b0;
        rdy        = 1'b1;
        fetch_req  = 1'b0;
        fetch_addr = '0;
        flush      = 1'b0;
        mem_done   = 1'b0;
        mem_data   = '0;

        // reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", {31'd0, fetch_ready}, 32'd1);
        check("rst_ok", {31'd0, fetch_ok}, 32'd0);
        check("rst_inst", fetch_inst, 32'd0);
        check("rst_maddr", mem_addr, 32'd0);
        check("rst_mreq", {31'd0, mem_req}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;

        // cold miss, then hit
        do_fetch(32'h0000_1000, 4, 0, 1'b0);
        do_fetch(32'h0000_1000, 1, 0, 1'b0);

        // three back-to-back hits
        do_fetch(32'h0000_1004, 2, 0, 1'b0);
        do_fetch(32'h0000_1008, 3, 0, 1'b0);
        a3[0] = 32'h0000_1000;
        a3[1] = 32'h0000_1004;
        a3[2] = 32'h0000_100B;
        fetch_req = 1'b1;
        for (int k = 0; k < 3; k++) begin
            fetch_addr = a3[k];
            @(posedge clk); #1;
            check("b2b_ok", {31'd0, fetch_ok}, 32'd1);
            check("b2b_inst", fetch_inst, mem_word(a3[k]));
            check("b2b_no_mreq", {31'd0, mem_req}, 32'd0);
        end
        fetch_req = 1'b0;
        @(posedge clk); #1;
        check("b2b_pulse_end", {31'd0, fetch_ok}, 32'd0);

        // conflict on the same index
        do_fetch(32'h0000_1400, 2, 0, 1'b0);
        do_fetch(32'h0000_1000, 3, 0, 1'b0);

        // flush during a miss, then flush coincident with mem_done
        do_fetch(32'h0000_2000, 4, 1, 1'b0);
        do_fetch(32'h0000_2000, 1, 0, 1'b0);
        do_fetch(32'h0000_3000, 3, 2, 1'b0);
        do_fetch(32'h0000_3000, 1, 0, 1'b0);

        // flush in IDLE overrides a hit and a miss request
        fetch_req  = 1'b1;
        fetch_addr = 32'h0000_1000;
        flush      = 1'b1;
        @(posedge clk); #1;
        check("idle_flush_hit_ok", {31'd0, fetch_ok}, 32'd0);
        fetch_addr = 32'h0000_9000;
        @(posedge clk); #1;
        fetch_req = 1'b0;
        flush     = 1'b0;
        check("idle_flush_miss_mreq", {31'd0, mem_req}, 32'd0);
        check("idle_flush_ready", {31'd0, fetch_ready}, 32'd1);

        // rdy low during a miss, then on a hit cycle
        do_fetch(32'h0000_4000, 4, 0, 1'b1);
        exp_data   = mem_word(32'h0000_4000);
        fetch_req  = 1'b1;
        fetch_addr = 32'h0000_4000;
        @(posedge clk); #1;
        fetch_req = 1'b0;
        rdy       = 1'b0;
        check("rdy_hit_ok", {31'd0, fetch_ok}, 32'd1);
        repeat (3) begin
            @(posedge clk); #1;
            check("rdy_hold_ok", {31'd0, fetch_ok}, 32'd1);
            check("rdy_hold_inst", fetch_inst, exp_data);
            check("rdy_hold_mreq", {31'd0, mem_req}, 32'd0);
        end
        rdy = 1'b1;
        @(posedge clk); #1;
        check("rdy_resume_ok", {31'd0, fetch_ok}, 32'd0);
        do_fetch(32'h0000_4000, 1, 0, 1'b0);

        // randomized traffic over a few indices and tags
        for (int n = 0; n < 60; n++) begin
            ra = ((($urandom_range(0, 3) * 32'h0001_2345) & 32'h003F_FFFF) << 10)
               | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
            if ($urandom_range(0, 9) == 0) begin
                fetch_req  = 1'b1;
                fetch_addr = ra;
                flush      = 1'b1;
                @(posedge clk); #1;
                fetch_req = 1'b0;
                flush     = 1'b0;
                check("rnd_idle_flush_ok", {31'd0, fetch_ok}, 32'd0);
                check("rnd_idle_flush_mreq", {31'd0, mem_req}, 32'd0);
            end else begin
                fm = $urandom_range(0, 5);
                if (fm > 2) fm = 0;
                do_fetch(ra, $urandom_range(1, 5), fm, ($urandom_range(0, 7) == 0));
            end
        end

        // asynchronous reset in the middle of a miss
        fetch_req  = 1'b1;
        fetch_addr = 32'h0000_5000;
        @(posedge clk); #1;
        fetch_req = 1'b0;
        check("rstmiss_mreq", {31'd0, mem_req}, 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check("rstmiss_mreq_drop", {31'd0, mem_req}, 32'd0);
        check("rstmiss_ok", {31'd0, fetch_ok}, 32'd0);
        check("rstmiss_maddr", mem_addr, 32'd0);
        line_word.delete();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check("rstmiss_ready", {31'd0, fetch_ready}, 32'd1);
        do_fetch(32'h0000_1000, 3, 0, 1'b0);
        do_fetch(32'h0000_1000, 1, 0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/icache_dm.md
Name: icache_dm

Overview:
- Direct-mapped instruction cache between instruction fetch and the memory controller's instruction port.
- Serves fetch requests from on-chip lines with 1-cycle hit latency.
- On a miss, issues one 4-byte read to the memory controller and fills the line.
- Supports a pipeline flush that discards any pending response without aborting an in-flight memory read.

Parameters:
- IDX_W, 8, index width; number of lines = 2^IDX_W, one 32-bit word per line.
- ADDR_W, 32, address width.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- rdy  in  1  global enable; when low, all state is held.
- fetch_req  in  1  fetch request, sampled only when fetch_ready=1.
- fetch_addr  in  32  byte address of the instruction; bits [1:0] are ignored.
- fetch_ready  out  1  cache can accept a request (state IDLE).
- fetch_ok  out  1  one-cycle pulse: fetch_inst is valid.
- fetch_inst  out  32  returned instruction word.
- flush  in  1  discard the pending or in-flight response.
- mem_req  out  1  read request to the memory controller's instruction port.
- mem_addr  out  32  word-aligned miss address.
- mem_done  in  1  one-cycle pulse from the memory controller: the word is on mem_data.
- mem_data  in  32  fill word, valid only in the cycle mem_done=1.

Behaviour:
- Address split: index = addr[IDX_W+1:2]; tag = addr[31:IDX_W+2].
- Arrays: valid[2^IDX_W] (reset), tag and data (not reset).
- Reset (rst=0, asynchronous):
  - state=IDLE, all valid bits=0, kill=0.
  - fetch_ok=0, fetch_inst=0, mem_addr=0.
  - mem_req drops to 0 immediately; it is combinational from state.
- rdy=0: no register updates, mem_req keeps its value, fetch_ok is held.
- States:
  - IDLE: fetch_ready=1, mem_req=0.
  - MISS: fetch_ready=0; mem_req = !mem_done (combinational).
- mem_req rule: mem_req must be low in the same cycle as mem_done. The controller restarts a read if its request input is high on the edge where it completes.
- mem_req is held high continuously from entering MISS until that mem_done cycle. The controller drives the byte address from it every cycle.
- mem_addr is registered at miss entry as {fetch_addr[31:2],2'b00} and is stable through MISS.
- IDLE, fetch_req=1, flush=0, hit (valid && tag match):
  - next edge: fetch_ok=1, fetch_inst=data[index].
  - state stays IDLE; back-to-back hits give one word per cycle.
- IDLE, fetch_req=1, flush=0, miss:
  - next edge: state=MISS, latch mem_addr and the miss index/tag, kill=0, fetch_ok=0.
- MISS, mem_done=1:
  - write data[idx]=mem_data, tag[idx]=latched tag, valid[idx]=1.
  - if kill=0 and flush=0: fetch_ok=1, fetch_inst=mem_data.
  - state=IDLE at the same edge.
- fetch_ok is otherwise 0 every cycle (pulse only).
- Flush:
  - In IDLE: the request in that cycle is ignored and fetch_ok=0 next cycle.
  - In MISS: set kill=1; the read completes and the line is filled, but no fetch_ok is produced.
  - flush in the same cycle as mem_done: fill occurs, no fetch_ok.
  - flush has priority over fetch_req.
- fetch_req while in MISS is ignored; the requester holds until fetch_ready=1.
- No write path and no invalidate other than reset.

Test Plan:
- Cold miss:
  - Stimulus: after reset, fetch 0x00001000; memory controller answers mem_done with 0x00500093 after 4 cycles.
  - Required: mem_req high with mem_addr=0x00001000; mem_req low in the mem_done cycle; fetch_ok next edge with fetch_inst=0x00500093; no second mem_req.
- Hit after fill:
  - Stimulus: fetch 0x00001000 again.
  - Required: fetch_ok one cycle later with 0x00500093; mem_req stays 0.
  - Stimulus: three back-to-back hits.
  - Required: three consecutive fetch_ok pulses.
- Conflict:
  - Stimulus: fill 0x00001000, then fetch 0x00001400 (same index, IDX_W=8).
  - Required: miss issued with mem_addr=0x00001400.
  - Stimulus: refetch 0x00001000.
  - Required: miss again.
- Flush during miss:
  - Stimulus: miss on 0x00002000, flush asserted 2 cycles later.
  - Required: mem_req stays high until mem_done; no fetch_ok; a later fetch of 0x00002000 hits.
  - Stimulus: flush coincident with mem_done.
  - Required: no fetch_ok.
- rdy low:
  - Stimulus: drop rdy for 3 cycles mid-miss and on a hit cycle.
  - Required: state, mem_addr, mem_req and fetch_ok frozen; operation resumes identically after rdy returns.
- Reset mid-miss:
  - Stimulus: assert rst=0 asynchronously during MISS.
  - Required: mem_req=0 immediately; fetch_ready=1 after release; the previously filled address now misses.
